// File: rtl/tb_wait_event.sv
// Wait-event engine: watches one selected wait input for N edges/levels, with optional timeout.
// Latency: done pulses one cycle after the completing hit. No backpressure: starts are ignored unless idle.
module tb_wait_event #(
    parameter int G_NB_WAIT = 5,
    parameter int G_SEL_W   = 3,
    parameter int G_CNT_W   = 8,
    parameter int G_TO_W    = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_start,
    input  logic                 i_abort,
    input  logic [G_SEL_W-1:0]   i_sel,
    input  logic [1:0]           i_evt,
    input  logic [G_CNT_W-1:0]   i_occ,
    input  logic [G_TO_W-1:0]    i_timeout,
    input  logic [G_NB_WAIT-1:0] i_wait,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [1:0]           o_status,
    output logic [G_TO_W-1:0]    o_elapsed
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [1:0] LP_ST_OK      = 2'b00;
    localparam logic [1:0] LP_ST_TIMEOUT = 2'b01;
    localparam logic [1:0] LP_ST_BAD_SEL = 2'b10;

    localparam int               LP_PAD = 2 ** G_SEL_W;
    localparam logic [G_SEL_W:0] LP_NB  = (G_SEL_W + 1)'(G_NB_WAIT);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [G_SEL_W-1:0]  r_sel;
    logic [1:0]          r_evt;
    logic [G_CNT_W-1:0]  r_occ;
    logic [G_TO_W-1:0]   r_timeout;
    logic                r_prev;
    logic [G_CNT_W-1:0]  r_occ_cnt;
    logic [G_TO_W-1:0]   r_elapsed;
    logic [1:0]          r_status;
    logic [G_TO_W-1:0]   r_elapsed_out;

    logic [LP_PAD-1:0]   w_wait_pad;
    logic                w_cur_new;
    logic                w_cur;
    logic                w_bad_sel;
    logic                w_hit;
    logic [G_CNT_W-1:0]  w_occ_nxt;
    logic [G_TO_W-1:0]   w_elapsed_nxt;
    logic                w_complete;
    logic                w_expire;
    logic                w_load_out;
    logic [1:0]          w_status_nxt;
    logic [G_TO_W-1:0]   w_elapsed_out_nxt;

    // Zero-padding lets out-of-range selects index safely; they never reach WAIT anyway.
    assign w_wait_pad    = LP_PAD'(i_wait);
    assign w_cur_new     = w_wait_pad[i_sel];
    assign w_cur         = w_wait_pad[r_sel];
    assign w_bad_sel     = ({1'b0, i_sel} >= LP_NB);
    assign w_occ_nxt     = r_occ_cnt + G_CNT_W'(1);
    assign w_elapsed_nxt = (&r_elapsed) ? r_elapsed : r_elapsed + G_TO_W'(1);
    assign w_complete    = w_hit && (w_occ_nxt == r_occ);
    assign w_expire      = (r_timeout != '0) && (w_elapsed_nxt == r_timeout);

    always_comb begin
        w_hit = 1'b0;
        case (r_evt)
            2'b00:   w_hit = !r_prev && w_cur;
            2'b01:   w_hit = r_prev && !w_cur;
            2'b10:   w_hit = w_cur;
            default: w_hit = !w_cur;
        endcase
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_load_out        = 1'b0;
        w_status_nxt      = LP_ST_OK;
        w_elapsed_out_nxt = '0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    if (w_bad_sel) begin
                        w_state_nxt  = S_DONE;
                        w_load_out   = 1'b1;
                        w_status_nxt = LP_ST_BAD_SEL;
                    end else begin
                        w_state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                // Abort beats everything; a completing hit beats expiry.
                if (i_abort) begin
                    w_state_nxt = S_IDLE;
                end else if (w_complete || w_expire) begin
                    w_state_nxt       = S_DONE;
                    w_load_out        = 1'b1;
                    w_status_nxt      = w_complete ? LP_ST_OK : LP_ST_TIMEOUT;
                    w_elapsed_out_nxt = w_elapsed_nxt;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_sel         <= '0;
            r_evt         <= '0;
            r_occ         <= '0;
            r_timeout     <= '0;
            r_prev        <= 1'b0;
            r_occ_cnt     <= '0;
            r_elapsed     <= '0;
            r_status      <= LP_ST_OK;
            r_elapsed_out <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load_out) begin
                r_status      <= w_status_nxt;
                r_elapsed_out <= w_elapsed_out_nxt;
            end
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_sel     <= i_sel;
                        r_evt     <= i_evt;
                        r_occ     <= (i_occ == '0) ? G_CNT_W'(1) : i_occ;
                        r_timeout <= i_timeout;
                        r_prev    <= w_cur_new;
                        r_occ_cnt <= '0;
                        r_elapsed <= '0;
                    end
                end
                S_WAIT: begin
                    r_prev    <= w_cur;
                    r_elapsed <= w_elapsed_nxt;
                    if (w_hit) begin
                        r_occ_cnt <= w_occ_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_busy    = (r_state == S_WAIT);
    assign o_done    = (r_state == S_DONE);
    assign o_status  = r_status;
    assign o_elapsed = r_elapsed_out;

endmodule

// File: tb/tb_tb_wait_event.sv
// Bench for tb_wait_event: vector table drives waits, a scoreboard checks each done pulse's cycle, status and elapsed.
module tb_tb_wait_event;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_start;
    logic        i_abort;
    logic [2:0]  i_sel;
    logic [1:0]  i_evt;
    logic [7:0]  i_occ;
    logic [31:0] i_timeout;
    logic [4:0]  i_wait;
    logic        o_busy;
    logic        o_done;
    logic [1:0]  o_status;
    logic [31:0] o_elapsed;

    tb_wait_event dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_start   (i_start),
        .i_abort   (i_abort),
        .i_sel     (i_sel),
        .i_evt     (i_evt),
        .i_occ     (i_occ),
        .i_timeout (i_timeout),
        .i_wait    (i_wait),
        .o_busy    (o_busy),
        .o_done    (o_done),
        .o_status  (o_status),
        .o_elapsed (o_elapsed)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  sel;
        logic [1:0]  evt;
        logic [7:0]  occ;
        logic [31:0] to;
        bit          init;
        int          tog[6];
        int          done_off;
        logic [1:0]  st;
        logic [31:0] el;
    } vec_t;

    typedef struct {
        int          cyc;
        logic [1:0]  st;
        logic [31:0] el;
    } exp_t;

    vec_t        vecs[$];
    exp_t        sb[$];
    int          cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;
    logic [1:0]  last_st = 2'b00;
    logic [31:0] last_el = 32'd0;

    always @(posedge clk) cyc++;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && o_done === 1'b1) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_done: got done, expected none (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                check("done_cycle", 64'(cyc), 64'(e.cyc));
                check("status", 64'(o_status), 64'(e.st));
                check("elapsed", 64'(o_elapsed), 64'(e.el));
            end
        end
    end

    task automatic add(input logic [2:0] sel, input logic [1:0] evt, input logic [7:0] occ,
                       input logic [31:0] to, input bit init,
                       input int t0, input int t1, input int t2, input int t3, input int t4,
                       input int off, input logic [1:0] st, input logic [31:0] el);
        vec_t v;
        v.sel = sel; v.evt = evt; v.occ = occ; v.to = to; v.init = init;
        v.tog[0] = t0; v.tog[1] = t1; v.tog[2] = t2; v.tog[3] = t3; v.tog[4] = t4; v.tog[5] = -1;
        v.done_off = off; v.st = st; v.el = el;
        vecs.push_back(v);
    endtask

    // Target bit is forced, the other aliases carry noise so a wrong select shows up.
    task automatic drive_wait(input logic [2:0] sel, input bit tgt);
        logic [4:0] w;
        w = 5'($urandom);
        if (sel < 3'd5) w[sel] = tgt;
        i_wait = w;
    endtask

    task automatic run_vec(input vec_t v);
        bit tgt;
        int t;
        exp_t e;
        @(negedge clk);
        i_start = 1'b0;
        i_abort = 1'b0;
        tgt = v.init;
        drive_wait(v.sel, tgt);
        @(negedge clk);
        i_sel = v.sel; i_evt = v.evt; i_occ = v.occ; i_timeout = v.to;
        for (int j = 0; j < 6; j++) if (v.tog[j] == 0) tgt = ~tgt;
        drive_wait(v.sel, tgt);
        i_start = 1'b1;
        t = cyc;
        e.cyc = t + v.done_off; e.st = v.st; e.el = v.el;
        sb.push_back(e);
        last_st = v.st;
        last_el = v.el;
        for (int k = 1; k <= v.done_off + 2; k++) begin
            @(negedge clk);
            i_start = 1'b0;
            if (k == 1) check("busy_after_start", 64'(o_busy), 64'(v.st != 2'b10));
            for (int j = 0; j < 6; j++) if (v.tog[j] == k) tgt = ~tgt;
            drive_wait(v.sel, tgt);
        end
        check("done_seen", 64'(sb.size()), 64'd0);
        sb.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        rst_n = 1'b0;
        i_start = 1'b0; i_abort = 1'b0; i_sel = '0; i_evt = '0; i_occ = '0; i_timeout = '0; i_wait = '0;
        #1;
        check("rst_busy", 64'(o_busy), 64'd0);
        check("rst_done", 64'(o_done), 64'd0);
        check("rst_status", 64'(o_status), 64'd0);
        check("rst_elapsed", 64'(o_elapsed), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        //   sel   evt    occ  to       init toggles                 off st     el
        add(3'd2, 2'b00, 8'd1, 32'd0,   0,   4, -1, -1, -1, -1,     5, 2'b00, 32'd4);
        add(3'd0, 2'b01, 8'd3, 32'd100, 1,  10, 15, 20, 25, 30,    31, 2'b00, 32'd30);
        add(3'd1, 2'b10, 8'd1, 32'd16,  0,  -1, -1, -1, -1, -1,    17, 2'b01, 32'd16);
        add(3'd1, 2'b10, 8'd1, 32'd16,  0,  16, -1, -1, -1, -1,    17, 2'b00, 32'd16);
        add(3'd6, 2'b00, 8'd1, 32'd0,   0,  -1, -1, -1, -1, -1,     1, 2'b10, 32'd0);
        add(3'd3, 2'b00, 8'd1, 32'd0,   0,   0,  4,  8, -1, -1,     9, 2'b00, 32'd8);
        add(3'd4, 2'b11, 8'd3, 32'd50,  1,   3,  5,  9, -1, -1,    10, 2'b00, 32'd9);
        add(3'd0, 2'b10, 8'd0, 32'd0,   1,  -1, -1, -1, -1, -1,     2, 2'b00, 32'd1);
        add(3'd2, 2'b10, 8'd3, 32'd0,   0,   2,  3,  6,  7, 10,    11, 2'b00, 32'd10);
        add(3'd1, 2'b00, 8'd1, 32'd5,   0,   5, -1, -1, -1, -1,     6, 2'b00, 32'd5);
        add(3'd3, 2'b01, 8'd1, 32'd1,   0,  -1, -1, -1, -1, -1,     2, 2'b01, 32'd1);
        foreach (vecs[i]) run_vec(vecs[i]);

        // Start with abort in IDLE is accepted; abort in the 5th WAIT cycle ends silently.
        @(negedge clk);
        i_sel = 3'd2; i_evt = 2'b00; i_occ = 8'd1; i_timeout = 32'd0;
        drive_wait(3'd2, 1'b0);
        i_start = 1'b1; i_abort = 1'b1;
        t = cyc;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            i_start = 1'b0;
            i_abort = (k == 5);
            drive_wait(3'd2, 1'b0);
            if (k == 1) check("start_with_abort_busy", 64'(o_busy), 64'd1);
            if (k == 6) begin
                check("abort_busy", 64'(o_busy), 64'd0);
                check("abort_status_kept", 64'(o_status), 64'(last_st));
                check("abort_elapsed_kept", 64'(o_elapsed), 64'(last_el));
            end
        end

        // Reset mid-WAIT clears everything asynchronously.
        @(negedge clk);
        i_sel = 3'd1; i_evt = 2'b10; i_occ = 8'd1; i_timeout = 32'd0;
        drive_wait(3'd1, 1'b0);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        drive_wait(3'd1, 1'b0);
        check("pre_reset_busy", 64'(o_busy), 64'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midwait_rst_busy", 64'(o_busy), 64'd0);
        check("midwait_rst_done", 64'(o_done), 64'd0);
        check("midwait_rst_status", 64'(o_status), 64'd0);
        check("midwait_rst_elapsed", 64'(o_elapsed), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // A start during the BAD_SEL done cycle must be ignored.
        @(negedge clk);
        i_sel = 3'd6; i_evt = 2'b00; i_occ = 8'd1; i_timeout = 32'd0;
        drive_wait(3'd6, 1'b0);
        i_start = 1'b1;
        t = cyc;
        sb.push_back('{cyc: t + 1, st: 2'b10, el: 32'd0});
        @(negedge clk);
        check("badsel_busy", 64'(o_busy), 64'd0);
        i_sel = 3'd1; i_evt = 2'b10;
        drive_wait(3'd1, 1'b1);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        check("start_in_done_ignored", 64'(o_busy), 64'd0);
        repeat (4) @(negedge clk);
        check("badsel_done_seen", 64'(sb.size()), 64'd0);
        sb.delete();

        run_vec(vecs[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/tb_wait_event.md
Name: tb_wait_event

Overview:
- Sequential wait-event engine in the testbench library.
- Sits directly downstream of the tb sequencer. The sequencer decodes a WAIT_EVENT scenario command into a select index, event type, occurrence count and timeout, then starts this block.
- Watches one of N aliased DUT wait signals.
- Returns a one-cycle done pulse with a status code. The sequencer stalls on that pulse before decoding the next scenario line.

Parameters:
- G_NB_WAIT, 5, number of monitored wait inputs (alias count).
- G_SEL_W, 3, width of select index; must satisfy 2**G_SEL_W >= G_NB_WAIT.
- G_CNT_W, 8, width of the occurrence-count field.
- G_TO_W, 32, width of the timeout counter, in clk cycles.

Ports:
- clk  in  1  testbench clock.
- rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  start request, single-cycle, sampled only in IDLE.
- i_abort  in  1  cancel the wait in progress.
- i_sel  in  G_SEL_W  index of the wait input to monitor.
- i_evt  in  2  event type: 00 rising edge, 01 falling edge, 10 level high, 11 level low.
- i_occ  in  G_CNT_W  number of occurrences required; 0 is treated as 1.
- i_timeout  in  G_TO_W  timeout in cycles; 0 means no timeout.
- i_wait  in  G_NB_WAIT  monitored signals, one bit per alias.
- o_busy  out  1  high from the cycle after an accepted start until done or abort.
- o_done  out  1  one-cycle completion pulse.
- o_status  out  2  00 OK, 01 TIMEOUT, 10 BAD_SEL; valid when o_done=1, held until the next done.
- o_elapsed  out  G_TO_W  cycles spent in WAIT; valid with o_done, held until the next done.

Behaviour:
- Reset: asynchronous, active-low.
  - During rst_n=0: o_busy=0, o_done=0, o_status=00, o_elapsed=0, state=IDLE, all internal counters 0.
- States: IDLE, WAIT, DONE.
- IDLE, when i_start=1 at cycle t:
  - Latch sel, evt, occ (0→1) and timeout.
  - Capture prev = i_wait[i_sel] at t.
  - Clear the occurrence counter and the elapsed counter.
  - If i_sel >= G_NB_WAIT: go to DONE with status BAD_SEL and elapsed=0.
  - Otherwise go to WAIT; o_busy=1 from t+1.
- WAIT, evaluated each cycle on the current input cur = i_wait[sel]:
  - hit = (evt=00 & !prev & cur) | (evt=01 & prev & !cur) | (evt=10 & cur) | (evt=11 & !cur).
  - prev <= cur every cycle.
  - elapsed <= elapsed+1 every cycle; saturates at all-ones.
  - On hit, occ_cnt <= occ_cnt+1. When hit and occ_cnt+1 == occ_latched: go to DONE with status OK.
  - Level modes count one occurrence per cycle the level holds. Example: level high with occ=3 completes on the 3rd high cycle, consecutive or not.
  - Timeout: when timeout != 0, elapsed+1 == timeout and the completing hit is not present, go to DONE with status TIMEOUT.
  - A completing hit and expiry in the same cycle resolve to OK.
- DONE: lasts exactly one cycle.
  - o_done=1, o_busy=0; o_status and o_elapsed are registered.
  - Next state is IDLE.
  - Latency: a completing hit at cycle k gives o_done=1 at k+1.
  - o_elapsed equals the number of WAIT cycles including the hit cycle.
- Edge at start: an edge occurring between t-1 and t is not counted, because prev is captured at t. The first detectable edge is between t and t+1.
- Start handling: i_start while not IDLE is ignored; no queueing. A start in the DONE cycle is ignored.
- i_abort in WAIT: go to IDLE next cycle with o_busy=0 and no o_done pulse; o_status and o_elapsed keep their previous values. i_abort in IDLE or DONE has no effect. If i_abort and i_start are both asserted in IDLE, the start is accepted.
- Reset mid-WAIT: returns immediately to IDLE with no done pulse.
- i_wait is sampled synchronously. The bench drives it away from the clk rising edge; no internal synchroniser.

Test Plan:
- Rising edge, sel=2, occ=1, timeout=0: i_wait[2] goes 0→1 at start+4 → o_done at start+5, status=00, elapsed=4.
- Falling edge, occ=3, timeout=100: three 1→0 transitions on i_wait[0] at cycles 10/20/30 after start → done one cycle after the 3rd, status=00, elapsed=30.
- Level high, timeout=16, i_wait[1] held 0 → o_done exactly 17 cycles after start, status=01, elapsed=16. Repeat with i_wait[1] rising in the 16th WAIT cycle → status=00 (hit wins).
- sel=6 with G_NB_WAIT=5 → o_done one cycle after start, status=10, elapsed=0, o_busy never asserted.
- Edge coincident with start: i_wait[3] rises in the same cycle as i_start → not counted; a later rise at +8 completes with elapsed=8.
- Abort and reset: i_abort at WAIT cycle 5 → o_busy low next cycle, no o_done, status unchanged. rst_n pulsed low mid-WAIT → all outputs 0 asynchronously, and the next start works normally.
